// File: rtl/maquina_sencilla_pkg.sv
// +--------------------------------------------------------------------+
// | maquina_sencilla_pkg: opcodes, FSM encoding, instruction fields    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package maquina_sencilla_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_RD_SRC = 3'd2;
  localparam logic [2:0] S_RD_DST = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WR     = 3'd5;

  function automatic logic [31:0] get_field(input logic [63:0] word,
                                            input int unsigned lsb,
                                            input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((word >> lsb) & mask);
  endfunction

  function automatic logic [1:0] get_opcode(input logic [63:0] word, input int unsigned addr_w);
    return 2'(get_field(word, 2 * addr_w, 2));
  endfunction

  function automatic logic [31:0] get_src(input logic [63:0] word, input int unsigned addr_w);
    return get_field(word, addr_w, addr_w);
  endfunction

  function automatic logic [31:0] get_dst(input logic [63:0] word, input int unsigned addr_w);
    return get_field(word, 0, addr_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/maquina_sencilla_param_alu.sv
// +--------------------------------------------------------------------+
// | ms_alu: combinational adder, equality compare and zero detect      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ms_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              eq,
  output logic              zero
);

  assign sum  = a + b;
  assign eq   = (a == b);
  assign zero = (sum == '0);

endmodule

`default_nettype wire

// File: rtl/maquina_sencilla_param.sv
// +--------------------------------------------------------------------+
// | maquina_sencilla_param: 4-opcode multicycle CPU, sync RAM + IO     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module maquina_sencilla_param
  import maquina_sencilla_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7,
  parameter int IO_CH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [IO_CH*DATA_W-1:0] in_data,
  input  logic [IO_CH-1:0]        in_valid,
  output logic [IO_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [IO_CH-1:0]        out_valid,
  input  logic [IO_CH-1:0]        out_ready,
  output logic                    fz,
  output logic [ADDR_W-1:0]       pc,
  output logic                    stall
);

  localparam logic [ADDR_W-1:0] C_IO_BASE = ADDR_W'((1 << ADDR_W) - IO_CH);

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_ir, r_a, r_b, r_result;
  logic              r_fz, r_first;
  logic [ADDR_W-1:0] r_pc;

  logic [1:0]        w_op, w_dec_op;
  logic [ADDR_W-1:0] w_src, w_dst, w_dec_dst;
  logic              w_src_io, w_dst_io, w_dst_reads_in;
  logic [IO_CH-1:0]  w_src_sel, w_dst_sel;
  logic [DATA_W-1:0] w_src_data, w_dst_data, w_a_now, w_b_op, w_sum;
  logic              w_src_valid, w_dst_valid, w_dst_ready, w_eq, w_zero;

  assign w_dec_op  = get_opcode(64'(mem_rdata), ADDR_W);
  assign w_dec_dst = ADDR_W'(get_dst(64'(mem_rdata), ADDR_W));
  assign w_op      = get_opcode(64'(r_ir), ADDR_W);
  assign w_src     = ADDR_W'(get_src(64'(r_ir), ADDR_W));
  assign w_dst     = ADDR_W'(get_dst(64'(r_ir), ADDR_W));
  assign w_src_io  = (w_src >= C_IO_BASE);
  assign w_dst_io  = (w_dst >= C_IO_BASE);
  // MOV never reads its destination, so an IO destination is output-only
  assign w_dst_reads_in = w_dst_io && (w_op != OP_MOV);

  always_comb begin
    w_src_sel  = '0;
    w_dst_sel  = '0;
    w_src_data = '0;
    w_dst_data = '0;
    for (int k = 0; k < IO_CH; k++) begin
      w_src_sel[k] = w_src_io && (w_src == C_IO_BASE + ADDR_W'(k));
      w_dst_sel[k] = w_dst_io && (w_dst == C_IO_BASE + ADDR_W'(k));
      if (w_src_sel[k]) w_src_data = in_data[k*DATA_W +: DATA_W];
      if (w_dst_sel[k]) w_dst_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_src_valid = |(in_valid & w_src_sel);
  assign w_dst_valid = |(in_valid & w_dst_sel);
  assign w_dst_ready = |(out_ready & w_dst_sel);
  assign w_a_now     = (r_first && !w_src_io) ? mem_rdata : r_a;
  assign w_b_op      = w_dst_io ? r_b : mem_rdata;

  ms_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (r_a),
    .b    (w_b_op),
    .sum  (w_sum),
    .eq   (w_eq),
    .zero (w_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_fz     <= 1'b0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_first  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= mem_rdata;
          if (w_dec_op == OP_BEQ) begin
            r_pc    <= r_fz ? w_dec_dst : r_pc + 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_pc    <= r_pc + 1'b1;
            r_state <= S_RD_SRC;
          end
        end
        S_RD_SRC: begin
          if (!w_src_io || w_src_valid) begin
            if (w_src_io) r_a <= w_src_data;
            r_first <= 1'b1;
            r_state <= S_RD_DST;
          end
        end
        S_RD_DST: begin
          r_first <= 1'b0;
          r_a     <= w_a_now;
          if (w_op == OP_MOV) begin
            r_result <= w_a_now;
            r_state  <= S_WR;
          end else if (!w_dst_reads_in || w_dst_valid) begin
            if (w_dst_reads_in) r_b <= w_dst_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_b <= w_b_op;
          if (w_op == OP_CMP) begin
            r_fz    <= w_eq;
            r_state <= S_FETCH;
          end else begin
            r_result <= w_sum;
            r_fz     <= w_zero;
            r_state  <= S_WR;
          end
        end
        S_WR: begin
          if (!w_dst_io || w_dst_ready) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    in_ready  = '0;
    out_valid = '0;
    stall     = 1'b0;
    case (r_state)
      S_FETCH:  mem_addr = r_pc;
      S_RD_SRC: begin
        mem_addr = w_src;
        if (w_src_io) begin
          in_ready = in_valid & w_src_sel;
          stall    = !w_src_valid;
        end
      end
      S_RD_DST: begin
        mem_addr = w_dst;
        if (w_dst_reads_in) begin
          in_ready = in_valid & w_dst_sel;
          stall    = !w_dst_valid;
        end
      end
      S_WR: begin
        mem_addr  = w_dst;
        out_valid = w_dst_sel;
        stall     = w_dst_io && !w_dst_ready;
      end
      default: ;
    endcase
  end

  assign mem_we    = (r_state == S_WR) && !w_dst_io;
  assign mem_wdata = r_result;
  assign out_data  = (|out_valid) ? r_result : '0;
  assign fz        = r_fz;
  assign pc        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_maquina_sencilla_param.sv
// +--------------------------------------------------------------------+
// | tb_maquina_sencilla_param: directed + random ISA-model checks      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_maquina_sencilla_param;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 7;
  localparam int IO_CH   = 4;
  localparam int DEPTH   = 128;
  localparam int IO_BASE = DEPTH - IO_CH;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_rdata;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_we;
  logic [IO_CH*DATA_W-1:0] in_data;
  logic [IO_CH-1:0]        in_valid;
  logic [IO_CH-1:0]        in_ready;
  logic [DATA_W-1:0]       out_data;
  logic [IO_CH-1:0]        out_valid;
  logic [IO_CH-1:0]        out_ready;
  logic                    fz;
  logic [ADDR_W-1:0]       pc;
  logic                    stall;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                out_cnt = 0;
  int                we_cnt  = 0;
  logic [IO_CH-1:0]  last_out_valid = '0;
  logic [DATA_W-1:0] last_out_data  = '0;

  int  m_pc;
  bit  m_fz;

  maquina_sencilla_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_CH(IO_CH)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fz(fz), .pc(pc), .stall(stall)
  );

  always #5 clk = ~clk;

  // synchronous RAM: data for an address appears the cycle after it is presented
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (reset && ((out_valid & out_ready) != '0)) begin
      out_cnt        <= out_cnt + 1;
      last_out_valid <= out_valid;
      last_out_data  <= out_data;
    end
    if (reset && mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] instr(input logic [1:0] op, input int s, input int d);
    return {op, 7'(s), 7'(d)};
  endfunction

  function automatic logic [DATA_W-1:0] rd(input int a);
    if (a >= IO_BASE) return in_data[(a - IO_BASE)*DATA_W +: DATA_W];
    return ref_mem[a];
  endfunction

  // ISA-level reference: one whole instruction per call
  task automatic model_step(output int cycles, output bit has_out, output int och,
                            output logic [DATA_W-1:0] oval);
    logic [DATA_W-1:0] ir, r;
    int op, s, d;
    bit wr;
    ir = ref_mem[m_pc];
    op = int'(ir[15:14]);
    s  = int'(ir[13:7]);
    d  = int'(ir[6:0]);
    has_out = 0; och = 0; oval = '0; wr = 0; r = '0;
    if (op == 3) begin
      m_pc   = m_fz ? d : (m_pc + 1) % DEPTH;
      cycles = 2;
    end else begin
      m_pc = (m_pc + 1) % DEPTH;
      if (op == 0) begin
        r = rd(s) + rd(d); m_fz = (r == 0); wr = 1; cycles = 6;
      end else if (op == 1) begin
        m_fz = (rd(s) == rd(d)); cycles = 5;
      end else begin
        r = rd(s); wr = 1; cycles = 5;
      end
    end
    if (wr) begin
      if (d >= IO_BASE) begin
        has_out = 1; och = d - IO_BASE; oval = r;
      end else begin
        ref_mem[d] = r;
      end
    end
  endtask

  initial begin
    int bad, prev_out, cyc, och, exp_out;
    bit has_out;
    logic [DATA_W-1:0] oval, v;

    reset = 1'b0; in_valid = '0; in_data = '0; out_ready = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    run(2);
    chk("rst_pc", pc, 0);
    chk("rst_fz", fz, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_out_data", out_data, 0);

    // ADD, then BEQ taken, CMP clearing fz, BEQ not taken
    mem[0]    <= instr(2'b00, 10, 11);
    mem[10]   <= 16'h0005;
    mem[11]   <= 16'hFFFB;
    mem[1]    <= instr(2'b11, 0, 16'h20);
    mem[16'h20] <= instr(2'b01, 10, 11);
    mem[16'h21] <= instr(2'b11, 0, 16'h40);
    run(1);
    reset = 1'b1;
    chk("rel_addr", mem_addr, 0);
    run(5);
    chk("add_we", mem_we, 1);
    chk("add_waddr", mem_addr, 11);
    chk("add_wdata", mem_wdata, 0);
    run(1);
    chk("add_pc", pc, 1);
    chk("add_fz", fz, 1);
    chk("add_fetch", mem_addr, 1);
    chk("add_mem", mem[11], 0);
    chk("add_we_cnt", we_cnt, 1);
    run(2);
    chk("beq_t_pc", pc, 16'h20);
    chk("beq_t_fetch", mem_addr, 16'h20);
    run(5);
    chk("cmp_pc", pc, 16'h21);
    chk("cmp_fz", fz, 0);
    run(2);
    chk("beq_nt_pc", pc, 16'h22);

    // input stall then output backpressure
    reset = 1'b0;
    mem[0] <= instr(2'b10, 124, 12);
    mem[1] <= instr(2'b10, 12, 127);
    run(1);
    reset = 1'b1;
    in_valid = 4'b1110;
    in_data  = 64'hAAAA_BBBB_CCCC_5555;
    run(2);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (stall !== 1'b1 || in_ready !== '0) bad++;
      run(1);
    end
    chk("in_stall", bad, 0);
    in_data[15:0] = 16'h1234;
    in_valid = 4'b1111;
    #1 chk("in_ready_on", in_ready, 4'b0001);
    run(1);
    chk("in_ready_pulse", in_ready, 0);
    chk("in_unstall", stall, 0);
    in_valid = '0;
    run(1);
    chk("mov_we", mem_we, 1);
    chk("mov_waddr", mem_addr, 12);
    run(1);
    chk("mov_pc", pc, 1);
    chk("mov_mem", mem[12], 16'h1234);

    out_ready = 4'b0111;
    prev_out = out_cnt;
    run(4);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 4'b1000 || out_data !== 16'h1234 || stall !== 1'b1 || mem_we !== 1'b0) bad++;
      run(1);
    end
    chk("out_hold", bad, 0);
    chk("out_no_xfer", out_cnt, prev_out);
    out_ready = 4'b1000;
    run(1);
    out_ready = '0;
    chk("out_xfer", out_cnt, prev_out + 1);
    chk("out_xfer_data", last_out_data, 16'h1234);
    chk("out_fetch", mem_addr, 2);
    chk("out_drop", out_valid, 0);

    // reset while an output is waiting
    reset = 1'b0;
    mem[0] <= instr(2'b10, 12, 127);
    run(1);
    reset = 1'b1;
    prev_out = out_cnt;
    run(6);
    chk("rw_wait", out_valid, 4'b1000);
    #2 reset = 1'b0;
    #1;
    chk("rw_out_valid", out_valid, 0);
    chk("rw_pc", pc, 0);
    chk("rw_stall", stall, 0);
    chk("rw_fz", fz, 0);
    out_ready = 4'b1111;
    run(1);
    chk("rw_no_xfer", out_cnt, prev_out);
    reset = 1'b1;
    chk("rw_rel_addr", mem_addr, 0);

    // random programs against the ISA model
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = DATA_W'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    in_valid = '1;
    out_ready = '1;
    m_pc = 0; m_fz = 0;
    run(1);
    reset = 1'b1;
    exp_out = out_cnt;
    for (int n = 0; n < 300; n++) begin
      in_data = {$urandom, $urandom};
      chk("rnd_pc", pc, m_pc);
      chk("rnd_fz", fz, m_fz);
      model_step(cyc, has_out, och, oval);
      run(cyc);
      if (has_out) exp_out++;
      chk("rnd_out_cnt", out_cnt, exp_out);
      if (has_out) begin
        chk("rnd_out_ch", last_out_valid, 32'(1 << och));
        chk("rnd_out_data", last_out_data, oval);
      end
    end
    chk("rnd_pc_end", pc, m_pc);
    chk("rnd_fz_end", fz, m_fz);
    for (int i = 0; i < IO_BASE; i++) chk("rnd_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
